// File: rtl/mem_stage_sb_pkg.sv
// rtl/mem_stage_sb_pkg.sv - shared length codes, FSM states and store-buffer entry type
package mem_stage_sb_pkg;

  localparam logic [2:0] LEN_B = 3'd1;
  localparam logic [2:0] LEN_H = 3'd2;
  localparam logic [2:0] LEN_W = 3'd4;

  localparam int SB_ADDR_W = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic [SB_ADDR_W-1:0] addr;
    logic [31:0]          data;
    logic [2:0]           len;
  } sb_entry_t;

  // Low 8*len bits of a buffered store, extended the way a load of that width expects.
  function automatic logic [31:0] fwd_extend(input logic [31:0] d, input logic [2:0] len,
                                             input logic sgn);
    case (len)
      LEN_B:   return {{24{sgn & d[7]}}, d[7:0]};
      LEN_H:   return {{16{sgn & d[15]}}, d[15:0]};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/mem_store_buf.sv
// rtl/mem_store_buf.sv - circular store FIFO with parallel word-address match (young_entry under MEM_STORE_FWD_EN)
module mem_store_buf
  import mem_stage_sb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  sb_entry_t            push_entry,
  input  logic [SB_ADDR_W-3:0] query_word,
  output sb_entry_t            head_entry,
  output logic                 full,
  output logic                 empty,
  output logic                 match
`ifdef MEM_STORE_FWD_EN
  ,
  output sb_entry_t            young_entry
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  sb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] idx;

  assign head_entry = mem[head];
  assign full       = (count == CNT_W'(DEPTH));
  assign empty      = (count == '0);

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= push_entry;
  end

  // Push on a full buffer is only issued together with a pop, so count never overflows.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Walk oldest to youngest so the last hit left standing is the youngest match.
  always_comb begin
    match = 1'b0;
    idx   = '0;
`ifdef MEM_STORE_FWD_EN
    young_entry = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if ((CNT_W'(i) < count) && (mem[idx].addr[SB_ADDR_W-1:2] == query_word)) begin
        match = 1'b1;
`ifdef MEM_STORE_FWD_EN
        young_entry = mem[idx];
`endif
      end
    end
  end

endmodule

// File: rtl/mem_stage_sb.sv
// rtl/mem_stage_sb.sv - MEM stage with store buffer; MEM_STORE_FWD_EN enables store-to-load forwarding
module mem_stage_sb
  import mem_stage_sb_pkg::*;
#(
  parameter int SB_DEPTH = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [DATA_W-1:0] wdata_o,
  input  logic              load,
  input  logic              store,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic [2:0]        length,
  input  logic              signed_,
  input  logic              ram_ready,
  input  logic [DATA_W-1:0] ram_data_i,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_o,
  output logic [2:0]        ram_length,
  output logic              ram_signed,
  output logic              ram_read,
  output logic              ram_write,
  output logic              stall_mem
);

  mem_state_t           state;
  logic [ADDR_W-1:0]    addr_q;
  logic [DATA_W-1:0]    data_q;
  logic [2:0]           len_q;
  logic                 sgn_q;
  logic                 rd_q;
  logic                 wr_q;

  sb_entry_t            push_entry;
  sb_entry_t            head_entry;
  logic [SB_ADDR_W-1:0] addr_ext;
  logic                 full, empty, match;
  logic                 ld, st, push, pop, done_load, blocked, fwd_hit;
  logic [DATA_W-1:0]    fwd_data;

  assign addr_ext   = SB_ADDR_W'(addr);
  assign push_entry = '{addr: addr_ext, data: data, len: length};

  // Load wins over a simultaneous store; nothing moves while rdy is low.
  assign ld        = load & rdy;
  assign st        = store & ~load & rdy;
  assign pop       = rdy & (state == S_DRAIN) & ram_ready;
  assign push      = st & (~full | pop);
  assign done_load = rdy & (state == S_LOAD) & ram_ready;

`ifdef MEM_STORE_FWD_EN
  sb_entry_t young_entry;
  assign fwd_hit  = ld & (state != S_LOAD) & match & (young_entry.addr == addr_ext) &
                    (young_entry.len >= length);
  assign fwd_data = fwd_extend(young_entry.data, length, signed_);
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

  assign blocked = match & ~fwd_hit;

  mem_store_buf #(.DEPTH(SB_DEPTH)) u_buf (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .push_entry (push_entry),
    .query_word (addr_ext[SB_ADDR_W-1:2]),
    .head_entry (head_entry),
    .full       (full),
    .empty      (empty),
    .match      (match)
`ifdef MEM_STORE_FWD_EN
    ,
    .young_entry(young_entry)
`endif
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      addr_q <= '0;
      data_q <= '0;
      len_q  <= '0;
      sgn_q  <= 1'b0;
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
    end else if (rdy) begin
      case (state)
        S_IDLE: begin
          if (ld && !blocked && !fwd_hit) begin
            state  <= S_LOAD;
            addr_q <= addr;
            len_q  <= length;
            sgn_q  <= signed_;
            rd_q   <= 1'b1;
          end else if ((!ld || blocked) && !empty) begin
            state  <= S_DRAIN;
            addr_q <= ADDR_W'(head_entry.addr);
            data_q <= head_entry.data;
            len_q  <= head_entry.len;
            sgn_q  <= 1'b0;
            wr_q   <= 1'b1;
          end
        end
        S_LOAD: begin
          if (ram_ready) begin
            state <= S_IDLE;
            rd_q  <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (ram_ready) begin
            state <= S_IDLE;
            wr_q  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ram_addr   = rst ? '0 : addr_q;
  assign ram_data_o = rst ? '0 : data_q;
  assign ram_length = rst ? '0 : len_q;
  assign ram_signed = rst ? 1'b0 : sgn_q;
  assign ram_read   = rst ? 1'b0 : rd_q;
  assign ram_write  = rst ? 1'b0 : wr_q;

  always_comb begin
    wd_o      = '0;
    wreg_o    = 1'b0;
    wdata_o   = '0;
    stall_mem = 1'b0;
    if (!rst) begin
      wd_o    = wd_i;
      wreg_o  = wreg_i;
      wdata_o = wdata_i;
      if (load) begin
        wdata_o   = fwd_hit ? fwd_data : ram_data_i;
        stall_mem = ~(done_load | fwd_hit);
      end else if (store) begin
        stall_mem = ~(rdy & (~full | pop));
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_sb.sv
// tb/tb_mem_stage_sb.sv - scoreboard bench for mem_stage_sb; expectations follow MEM_STORE_FWD_EN
module tb_mem_stage_sb;
  import mem_stage_sb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic [4:0]  wd_i = '0;
  logic        wreg_i = 1'b0;
  logic [31:0] wdata_i = '0;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        load = 1'b0, store = 1'b0, signed_ = 1'b0;
  logic [31:0] addr = '0, data = '0;
  logic [2:0]  length = '0;
  logic        ram_ready = 1'b0;
  logic [31:0] ram_data_i = '0;
  logic [31:0] ram_addr, ram_data_o;
  logic [2:0]  ram_length;
  logic        ram_signed, ram_read, ram_write, stall_mem;

  mem_stage_sb dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .load(load), .store(store), .addr(addr), .data(data), .length(length), .signed_(signed_),
    .ram_ready(ram_ready), .ram_data_i(ram_data_i), .ram_addr(ram_addr),
    .ram_data_o(ram_data_o), .ram_length(ram_length), .ram_signed(ram_signed),
    .ram_read(ram_read), .ram_write(ram_write), .stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  len;
    logic        sgn;
  } ram_op_t;

  ram_op_t exp_q[$];
  int      n_tests = 0;
  int      n_fail = 0;
  bit      auto_ram = 1'b0;
  bit      hold_ready = 1'b0;
  bit      seen = 1'b0;
  int      w;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_pat(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3E1};
  endfunction

  task automatic ram_accept();
    ram_op_t e;
    if (exp_q.size() == 0) begin
      chk("ram_unexpected", {ram_write, ram_read}, 2'b00);
      return;
    end
    e = exp_q.pop_front();
    chk("ram_kind", {ram_write, ram_read}, {e.wr, ~e.wr});
    chk("ram_addr", ram_addr, e.addr);
    chk("ram_len", ram_length, e.len);
    chk("ram_signed", ram_signed, e.sgn);
    if (e.wr) chk("ram_wdata", ram_data_o, e.data);
    ram_data_i = e.wr ? 32'h0 : rd_pat(e.addr);
  endtask

  // RAM model: auto mode acks each request after one cycle; manual mode follows hold_ready.
  always @(negedge clk) begin
    if (!ram_read && !ram_write) seen = 1'b0;
    if (auto_ram) begin
      if (ram_ready) ram_ready = 1'b0;
      else if (!rst && (ram_read || ram_write)) begin
        ram_accept();
        ram_ready = 1'b1;
      end
    end else begin
      ram_ready = hold_ready;
      if (hold_ready && !seen && (ram_read || ram_write)) begin
        ram_accept();
        seen = 1'b1;
      end
    end
  end

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] len,
                          input int exp_wait, input string tag);
    int n = 0;
    ram_op_t e;
    @(negedge clk);
    store = 1'b1; addr = a; data = d; length = len;
    #1;
    while (stall_mem && n < 100) begin @(negedge clk); #1; n++; end
    chk({tag, "_done"}, n < 100, 1);
    if (exp_wait >= 0) chk({tag, "_wait"}, n, exp_wait);
    e.wr = 1'b1; e.addr = a; e.data = d; e.len = len; e.sgn = 1'b0;
    exp_q.push_back(e);
    @(posedge clk); #1;
    store = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [2:0] len, input logic sgn,
                         input bit use_ram, input logic [31:0] exp_data, input int exp_wait,
                         input string tag);
    int n = 0;
    ram_op_t e;
    if (use_ram) begin
      e.wr = 1'b0; e.addr = a; e.data = '0; e.len = len; e.sgn = sgn;
      exp_q.push_back(e);
    end
    @(negedge clk);
    load = 1'b1; addr = a; length = len; signed_ = sgn;
    #1;
    while (stall_mem && n < 100) begin @(negedge clk); #1; n++; end
    chk({tag, "_done"}, n < 100, 1);
    if (exp_wait >= 0) chk({tag, "_wait"}, n, exp_wait);
    chk({tag, "_data"}, wdata_o, exp_data);
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || ram_read || ram_write) && n < 200) begin
      @(negedge clk); #1; n++;
    end
    chk({tag, "_drain"}, n < 200, 1);
  endtask

  initial begin
    ram_op_t e;

    // outputs forced low while reset is held, even with live inputs
    @(negedge clk);
    wd_i = 5'h1A; wreg_i = 1'b1; wdata_i = 32'h1234_5678; load = 1'b1; addr = 32'h40;
    #1;
    chk("rst_wd", wd_o, 0);
    chk("rst_wreg", wreg_o, 0);
    chk("rst_wdata", wdata_o, 0);
    chk("rst_stall", stall_mem, 0);
    chk("rst_rw", {ram_read, ram_write}, 0);
    @(negedge clk);
    rst = 1'b0; load = 1'b0;
    #1;
    chk("pass_wd", wd_o, 5'h1A);
    chk("pass_wreg", wreg_o, 1);
    chk("pass_wdata", wdata_o, 32'h1234_5678);
    chk("idle_stall", stall_mem, 0);

    auto_ram = 1'b1;
    do_load(32'h40, LEN_W, 1'b0, 1'b1, rd_pat(32'h40), 1, "plain_lw");
    wait_idle("plain");

    // RAW hazard on the same word: write must reach RAM before the read
    do_store(32'h100, 32'hCAFE_F00D, LEN_W, 0, "haz_sw");
    do_load(32'h102, LEN_H, 1'b0, 1'b1, rd_pat(32'h102), -1, "haz_lh");
    wait_idle("haz");

    do_store(32'h200, 32'h8000_00F0, LEN_W, 0, "fwd_sw");
`ifdef MEM_STORE_FWD_EN
    do_load(32'h200, LEN_B, 1'b1, 1'b0, 32'hFFFF_FFF0, 0, "fwd_lb");
`else
    do_load(32'h200, LEN_B, 1'b1, 1'b1, rd_pat(32'h200), -1, "fwd_lb");
`endif
    wait_idle("fwd");

    // narrower buffered store cannot satisfy a wider load
    do_store(32'h210, 32'h0000_0011, LEN_B, 0, "part_sb");
    do_load(32'h210, LEN_W, 1'b0, 1'b1, rd_pat(32'h210), -1, "part_lw");
    wait_idle("part");

    // load and store together: only the load happens
    store = 1'b1; data = 32'hDEAD_BEEF;
    do_load(32'h500, LEN_W, 1'b0, 1'b1, rd_pat(32'h500), 1, "both_lw");
    store = 1'b0;
    wait_idle("both");

    // full buffer with RAM never ready: only the fifth store stalls
    auto_ram = 1'b0; hold_ready = 1'b0;
    for (int i = 0; i < 4; i++) do_store(32'h600 + 4 * i, 32'hA000_0000 + i, LEN_W, 0, "full_fill");
    @(negedge clk);
    store = 1'b1; addr = 32'h610; data = 32'hA000_0004; length = LEN_W;
    #1;
    chk("full_stall_5th", stall_mem, 1);
    @(negedge clk); #1;
    chk("full_stall_hold", stall_mem, 1);
    auto_ram = 1'b1;
    w = 0;
    while (stall_mem && w < 100) begin @(negedge clk); #1; w++; end
    chk("full_accept", w < 100, 1);
    e.wr = 1'b1; e.addr = 32'h610; e.data = 32'hA000_0004; e.len = LEN_W; e.sgn = 1'b0;
    exp_q.push_back(e);
    @(posedge clk); #1;
    store = 1'b0;
    wait_idle("full");

    // head completes in the same cycle a store hits the full buffer
    auto_ram = 1'b0; hold_ready = 1'b0;
    for (int i = 0; i < 4; i++) do_store(32'h700 + 4 * i, 32'hB000_0000 + i, LEN_W, 0, "sim_fill");
    hold_ready = 1'b1;
    @(negedge clk);
    store = 1'b1; addr = 32'h710; data = 32'hB000_0004; length = LEN_W;
    #1;
    chk("sim_stall", stall_mem, 0);
    e.wr = 1'b1; e.addr = 32'h710; e.data = 32'hB000_0004; e.len = LEN_W; e.sgn = 1'b0;
    exp_q.push_back(e);
    @(posedge clk); #1;
    store = 1'b0; hold_ready = 1'b0;
    chk("sim_count", dut.u_buf.count, 4);
    auto_ram = 1'b1;
    wait_idle("sim");

    // rdy low mid-load while RAM reports ready: request frozen
    auto_ram = 1'b0; hold_ready = 1'b0;
    e.wr = 1'b0; e.addr = 32'h300; e.data = '0; e.len = LEN_W; e.sgn = 1'b0;
    exp_q.push_back(e);
    @(negedge clk);
    load = 1'b1; addr = 32'h300; length = LEN_W; signed_ = 1'b0;
    #1;
    chk("rdy0_req_stall", stall_mem, 1);
    @(negedge clk); #1;
    chk("rdy0_read", ram_read, 1);
    rdy = 1'b0; hold_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("rdy0_addr", ram_addr, 32'h300);
      chk("rdy0_read_hold", ram_read, 1);
      chk("rdy0_stall", stall_mem, 1);
    end
    rdy = 1'b1;
    #1;
    chk("rdy0_done_stall", stall_mem, 0);
    chk("rdy0_data", wdata_o, rd_pat(32'h300));
    @(posedge clk); #1;
    load = 1'b0; hold_ready = 1'b0;
    @(negedge clk); #1;
    chk("rdy0_released", ram_read, 0);
    chk("rdy0_q", exp_q.size(), 0);

    // reset with three queued stores abandons them
    for (int i = 0; i < 3; i++) do_store(32'h800 + 4 * i, 32'hC000_0000 + i, LEN_W, 0, "rq_fill");
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rq_rst_write", ram_write, 0);
    chk("rq_rst_addr", ram_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rq_count", dut.u_buf.count, 0);
    chk("rq_write", ram_write, 0);
    chk("rq_stall", stall_mem, 0);
    exp_q.delete();
    auto_ram = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    chk("rq_quiet", {ram_read, ram_write}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
